// File: rtl/text_buf_pkg.sv
// rtl/text_buf_pkg.sv - character codes and state encoding for the text buffer controller
package text_buf_pkg;

    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR_ALL,
        IDLE,
        CLEAR_ROW
    } buf_state_t;

    function automatic logic is_printable(input logic [7:0] ch);
        return (ch >= CH_PRINT_LO) && (ch <= CH_PRINT_HI);
    endfunction

endpackage

// File: rtl/text_ram_dp.sv
// rtl/text_ram_dp.sv - character RAM, one synchronous write port and one registered read port
// A same-address read and write in one cycle returns the previous contents.
module text_ram_dp #(
    parameter int DEPTH  = 128,
    parameter int DATA_W = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/text_buffer_ctrl.sv
// rtl/text_buffer_ctrl.sv - cursor, control-code and scroll handling over a circular character grid
// Screen rows map to RAM rows through top_row so a scroll never moves stored text.
module text_buffer_ctrl
    import text_buf_pkg::*;
#(
    parameter int         COLS      = 32,
    parameter int         ROWS      = 4,
    parameter int         COL_W     = $clog2(COLS),
    parameter int         ROW_W     = $clog2(ROWS),
    parameter bit         SCROLL_EN = 1'b1,
    parameter logic [7:0] FILL_CHAR = 8'h20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    input  logic [ROW_W-1:0] rd_row,
    input  logic [COL_W-1:0] rd_col,
    output logic [7:0]       rd_data,
    output logic [ROW_W-1:0] cursor_row,
    output logic [COL_W-1:0] cursor_col,
    output logic [ROW_W-1:0] top_row,
    output logic             busy
);

    localparam int DEPTH  = ROWS * COLS;
    localparam int ADDR_W = $clog2(DEPTH);

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] LAST_CCNT = ADDR_W'(COLS - 1);

    function automatic logic [ROW_W-1:0] phys_row(input logic [ROW_W-1:0] srow,
                                                  input logic [ROW_W-1:0] top);
        logic [ROW_W:0] sum;
        sum = {1'b0, srow} + {1'b0, top};
        if (sum >= (ROW_W+1)'(ROWS)) begin
            sum = sum - (ROW_W+1)'(ROWS);
        end
        return sum[ROW_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [ROW_W-1:0] prow,
                                                    input logic [COL_W-1:0] col);
        return ADDR_W'(prow) * ADDR_W'(COLS) + ADDR_W'(col);
    endfunction

    buf_state_t        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              accept;
    logic              lf_req;
    logic              we;
    logic [7:0]        wdata;
    logic [ROW_W-1:0]  wr_srow;
    logic [COL_W-1:0]  wr_col;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] raddr;

    assign rx_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = rx_valid && rx_ready;
    assign lf_req   = accept && ((is_printable(rx_data) && (cursor_col == LAST_COL)) ||
                                 (rx_data == CH_LF));
    assign raddr    = cell_addr(phys_row(rd_row, top_row), rd_col);

    // Write port: clears sweep linearly or along one row; backspace writes at the new position.
    always_comb begin
        we      = 1'b0;
        wdata   = FILL_CHAR;
        wr_srow = cursor_row;
        wr_col  = cursor_col;
        case (state)
            CLEAR_ALL: we = 1'b1;
            CLEAR_ROW: begin
                we     = 1'b1;
                wr_col = clr_cnt[COL_W-1:0];
            end
            IDLE: begin
                if (accept) begin
                    if (is_printable(rx_data)) begin
                        we    = 1'b1;
                        wdata = rx_data;
                    end else if (rx_data == CH_BS) begin
                        if (cursor_col != '0) begin
                            we     = 1'b1;
                            wr_col = cursor_col - 1'b1;
                        end else if (cursor_row != '0) begin
                            we      = 1'b1;
                            wr_srow = cursor_row - 1'b1;
                            wr_col  = LAST_COL;
                        end
                    end
                end
            end
            default: we = 1'b0;
        endcase
        waddr = (state == CLEAR_ALL) ? clr_cnt : cell_addr(phys_row(wr_srow, top_row), wr_col);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CLEAR_ALL;
            clr_cnt    <= '0;
            cursor_row <= '0;
            cursor_col <= '0;
            top_row    <= '0;
        end else begin
            case (state)
                CLEAR_ALL: begin
                    if (clr_cnt == LAST_ADDR) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                CLEAR_ROW: begin
                    if (clr_cnt == LAST_CCNT) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) begin
                        if (is_printable(rx_data)) begin
                            cursor_col <= (cursor_col == LAST_COL) ? '0 : cursor_col + 1'b1;
                        end else begin
                            case (rx_data)
                                CH_CR, CH_LF: cursor_col <= '0;
                                CH_BS: begin
                                    if (cursor_col != '0) begin
                                        cursor_col <= cursor_col - 1'b1;
                                    end else if (cursor_row != '0) begin
                                        cursor_row <= cursor_row - 1'b1;
                                        cursor_col <= LAST_COL;
                                    end
                                end
                                CH_FF: begin
                                    cursor_row <= '0;
                                    cursor_col <= '0;
                                    top_row    <= '0;
                                    clr_cnt    <= '0;
                                    state      <= CLEAR_ALL;
                                end
                                default: cursor_col <= cursor_col;
                            endcase
                        end
                        // The scroll's fresh bottom row is the RAM row that top_row just left.
                        if (lf_req) begin
                            if (cursor_row != LAST_ROW) begin
                                cursor_row <= cursor_row + 1'b1;
                            end else if (SCROLL_EN) begin
                                top_row <= (top_row == LAST_ROW) ? '0 : top_row + 1'b1;
                                clr_cnt <= '0;
                                state   <= CLEAR_ROW;
                            end else begin
                                cursor_row <= '0;
                            end
                        end
                    end
                end
                default: state <= CLEAR_ALL;
            endcase
        end
    end

    text_ram_dp #(
        .DEPTH (DEPTH),
        .DATA_W(8)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (raddr),
        .rd_data(rd_data)
    );

endmodule

// File: doc/text_buffer_ctrl.md
Name: text_buffer_ctrl

Overview:
Parametrised character-grid text buffer fed by the UART byte stream and scanned by the VGA text generator. It owns the cursor and a COLS x ROWS dual-port character RAM. It interprets control codes (CR, LF, BS, FF) and scrolls the screen through a circular top-row pointer. It replaces the ad-hoc cursor logic in the top level with a handshaked, boundary-correct block.

Parameters:
COLS, 32, characters per row (>=2)
ROWS, 4, rows on screen (>=2, need not be a power of 2)
COL_W, $clog2(COLS), column index width
ROW_W, $clog2(ROWS), row index width
SCROLL_EN, 1, 1 = scroll on line feed at bottom row; 0 = wrap cursor to row 0 without clearing
FILL_CHAR, 8'h20, value written by every clear operation and by backspace

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  asynchronous, active-high reset
rx_valid  in  1  byte available from UART receiver
rx_data  in  8  received byte
rx_ready  out  1  byte accepted on the cycle where rx_valid && rx_ready
rd_row  in  ROW_W  screen row requested by the text generator (0 = top of screen)
rd_col  in  COL_W  screen column requested by the text generator
rd_data  out  8  character at (rd_row, rd_col); registered, 1-cycle latency
cursor_row  out  ROW_W  current screen row of the cursor
cursor_col  out  COL_W  current column of the cursor
top_row  out  ROW_W  physical RAM row currently shown at screen row 0
busy  out  1  high while a clear sequence is running

Behaviour:
- States: CLEAR_ALL, IDLE, CLEAR_ROW. rx_ready = (state == IDLE); busy = !rx_ready.
- Reset values: state CLEAR_ALL, clear counter 0, cursor (0,0), top_row 0, rd_data 0. Reset asserted mid-operation restarts CLEAR_ALL from address 0.
- CLEAR_ALL: writes FILL_CHAR to one cell per cycle, covering all ROWS*COLS cells, then goes to IDLE. rx_ready first goes high exactly ROWS*COLS cycles after reset deassertion.
- Physical row = (screen_row + top_row) mod ROWS, computed by add then conditional subtract. This mapping applies to writes and reads.
- Accepted byte, in IDLE:
  - 0x20..0x7E: write at (cursor_row, cursor_col). If cursor_col < COLS-1, cursor_col++. Otherwise cursor_col = 0 and a line feed is performed.
  - 0x0D (CR): cursor_col = 0, no write.
  - 0x0A (LF): cursor_col = 0, then line feed.
  - 0x08 (BS): if cursor_col > 0, cursor_col-- and FILL_CHAR is written at the new position. If cursor_col = 0 and cursor_row > 0, move to (row-1, COLS-1) and write FILL_CHAR there. At (0,0): no-op.
  - 0x0C (FF): cursor (0,0), top_row 0, enter CLEAR_ALL.
  - All other bytes are ignored and still accepted.
- Line feed:
  - If cursor_row < ROWS-1: cursor_row++.
  - Else if SCROLL_EN: top_row = (top_row+1) mod ROWS and cursor_row stays at ROWS-1. Enter CLEAR_ROW, which writes FILL_CHAR to the new bottom physical row for COLS cycles, then returns to IDLE.
  - Else: cursor_row = 0 with no clear.
- Printable byte at the last column with a scroll: the character is written in the accept cycle; CLEAR_ROW starts the next cycle.
- rx_valid while busy: the byte is not consumed; the sender holds it.
- RAM: one write port driven by the FSM, one read port for the video path. A read and a write to the same address in the same cycle returns the old data.
- The read path runs in every state, including CLEAR states; the screen may show partial clears.

Decomposition:
- Package text_buf_pkg: ASCII constants (CH_BS=8'h08, CH_LF=8'h0A, CH_FF=8'h0C, CH_CR=8'h0D, printable bounds 8'h20/8'h7E) and the state enum {CLEAR_ALL, IDLE, CLEAR_ROW}.
- One sub-module: text_ram_dp.
  - Parameters: DEPTH=ROWS*COLS, width 8.
  - One synchronous write port and one registered read port.
  - Address = phys_row*COLS + col.

Test Plan:
- Reset, hold rx_valid=0 -> rx_ready=0 for 128 cycles after release, then 1; reads of all 128 cells return 0x20.
- Send 0x41, 0x42 -> rd(0,0)=0x41, rd(0,1)=0x42 one cycle after the address is presented; cursor=(0,2).
- Send 32 x 0x78 from (0,0) -> row 0 all 0x78; cursor=(1,0); no busy cycles.
- From cursor (3,5) with SCROLL_EN=1, send 0x0A -> busy for exactly 32 cycles; top_row increments by 1; screen row 0 shows the old screen row 1; screen row 3 is all 0x20; cursor=(3,0). Repeat 4 times -> top_row wraps 3->0.
- Cursor (1,0), send 0x08 -> cursor=(0,31) and rd(0,31)=0x20. At (0,0), send 0x08 -> cursor unchanged, no write.
- Mid-text, send 0x0C while holding a second rx_valid byte -> busy for 128 cycles; that byte is accepted only afterwards and written at (0,0). Assert reset during the clear -> the clear restarts and rx_ready stays low for 128 cycles after release.
